simd_pipe_stage: RTL and testbench
==================================

Name: simd_pipe_stage

Overview:
Parametrised pipeline stage register for the SIMD AES datapath. Replaces the fixed-field, free-running inter-stage registers with one generic stage:
- DATA_W-wide payload
- valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and stalls do not ripple combinationally
- synchronous flush for squashing wrong-path or hazard instructions

Instantiated between IF/ID/EX/MEM/WB, with the control and data fields packed into the payload.

Parameters:
DATA_W, 64, payload width in bits (≥1)
CNT_W, 16, width of statistics counters (only used with STAGE_STATS_EN)

Ports:
clk  input  1  stage clock, all state on rising edge
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream presents in_data
in_ready  output  1  stage can accept; registered
in_data  input  DATA_W  upstream payload
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts
out_data  output  DATA_W  payload of oldest held entry
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0
xfer_cnt  output  CNT_W  completed output transfers

Behaviour:
- Storage: main entry (main_v, main_d) drives out_valid/out_data; skid entry (skid_v, skid_d) holds overflow.
- States:
  - EMPTY: main_v=0, skid_v=0
  - BUSY: main_v=1, skid_v=0
  - FULL: main_v=1, skid_v=1
- in_ready = !skid_v, taken from a flop with no combinational path from out_ready. out_valid = main_v. out_data = main_d.
- Accept: in_valid && in_ready. Deliver: out_valid && out_ready.
- Latency: a word accepted at edge N is on out_data after edge N (visible in cycle N+1). Throughput is 1 word/cycle when out_ready stays high.
- Transitions:
  - EMPTY + accept → BUSY, main_d ← in_data.
  - BUSY + accept + deliver → BUSY, main_d ← in_data.
  - BUSY + deliver only → EMPTY.
  - BUSY + accept, no deliver → FULL, skid_d ← in_data.
  - BUSY + neither → BUSY (hold).
  - FULL + deliver → BUSY, main_d ← skid_d, skid_v ← 0. No accept is possible because in_ready=0.
  - FULL + no deliver → hold.
- Order is strictly FIFO. No word is dropped or duplicated.
- Flush:
  - At the edge where flush=1, main_v and skid_v ← 0 and the state becomes EMPTY.
  - An accept in the same cycle is discarded; flush dominates in_valid.
  - A deliver in the same cycle still counts as completed downstream, since downstream already sampled it.
  - in_ready=1 from the next cycle.
- Payload registers are not cleared on flush. out_data is don't-care while out_valid=0.
- Reset: asynchronous assertion takes effect immediately, with no clock needed. Values under reset:
  - main_v=0, skid_v=0, in_ready=1 (the in_ready flop resets to 1)
  - main_d=0, skid_d=0
  - stall_cnt=0, xfer_cnt=0
- Deassertion is synchronous to clk and is handled by the upstream reset synchroniser. Reset mid-transfer loses all held words.
- in_data must be stable while in_valid=1 && in_ready=0. in_valid may drop without a transfer.

Optional Feature:
Macro: STAGE_STATS_EN
- Defined:
  - stall_cnt increments each cycle with out_valid=1 && out_ready=0.
  - xfer_cnt increments on each deliver.
  - Both saturate at 2^CNT_W−1 with no wrap.
  - Both clear on rst. They do not clear on flush.
- Undefined: the counters are not synthesised and stall_cnt, xfer_cnt are tied to 0. The ports remain so the interface is identical.

Test Plan:
- Reset and idle:
  - Stimulus: assert rst mid-cycle with no clock edge.
  - Response: out_valid=0, in_ready=1, out_data=0 immediately. After release with in_valid=0 for 5 cycles, out_valid stays 0.
- Streaming:
  - Stimulus: out_ready=1; send 0x01..0x10 on consecutive cycles.
  - Response: out_data shows 0x01..0x10 one cycle later, one per cycle, and in_ready stays 1 throughout. With STAGE_STATS_EN, xfer_cnt=16.
- Backpressure/skid:
  - Stimulus: send 0xA, 0xB, 0xC with out_ready=0 from the cycle 0xA appears.
  - Response: state FULL, in_ready=0, 0xC held upstream. Raising out_ready drains 0xA, 0xB, 0xC in order with no loss.
  - With STAGE_STATS_EN, stall_cnt equals the number of held cycles.
- Flush:
  - Stimulus: in FULL (0xA, 0xB), pulse flush together with in_valid=1, in_data=0xC.
  - Response: next cycle out_valid=0, in_ready=1, and 0xC never appears at the output.
- Simultaneous accept/deliver in BUSY:
  - Stimulus: main=0x5, in_data=0x6, out_ready=1.
  - Response: 0x5 delivered, main becomes 0x6, state stays BUSY, skid_v stays 0.
- Saturation (CNT_W=4, STAGE_STATS_EN):
  - Stimulus: hold out_valid=1, out_ready=0 for 20 cycles.
  - Response: stall_cnt=15 and stays there.

Source files
------------

// File: rtl/simd_pipe_stage.sv
// Generic valid/ready pipeline stage with a 2-entry skid buffer and synchronous flush.
// Optional statistics counters are enabled by defining STAGE_STATS_EN.
module simd_pipe_stage #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  xfer_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q;
  logic              main_v_q;
  logic              skid_v_q;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] skid_data_q;

  logic accept;
  logic deliver;

  assign accept    = in_valid && in_ready_q;
  assign deliver   = main_v_q && out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = main_v_q;
  assign out_data  = main_data_q;

  // in_ready_q is updated alongside skid_v_q so it never depends on out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      skid_data_q <= '0;
    end else if (flush) begin
      state_q    <= EMPTY;
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q     <= BUSY;
            main_v_q    <= 1'b1;
            main_data_q <= in_data;
          end
        end
        BUSY: begin
          if (accept && deliver) begin
            main_data_q <= in_data;
          end else if (deliver) begin
            state_q  <= EMPTY;
            main_v_q <= 1'b0;
          end else if (accept) begin
            state_q     <= FULL;
            skid_v_q    <= 1'b1;
            in_ready_q  <= 1'b0;
            skid_data_q <= in_data;
          end
        end
        FULL: begin
          if (deliver) begin
            state_q     <= BUSY;
            skid_v_q    <= 1'b0;
            in_ready_q  <= 1'b1;
            main_data_q <= skid_data_q;
          end
        end
        default: begin
          state_q    <= EMPTY;
          main_v_q   <= 1'b0;
          skid_v_q   <= 1'b0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef STAGE_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] xfer_q, xfer_d;

  // Counters keep running across flush; a deliver in a flush cycle still counts.
  always_comb begin
    stall_d = stall_q;
    xfer_d  = xfer_q;
    if (main_v_q && !out_ready && (stall_q != CNT_MAX)) stall_d = stall_q + CNT_W'(1);
    if (deliver && (xfer_q != CNT_MAX))                 xfer_d  = xfer_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      xfer_q  <= '0;
    end else begin
      stall_q <= stall_d;
      xfer_q  <= xfer_d;
    end
  end

  assign stall_cnt = stall_q;
  assign xfer_cnt  = xfer_q;
`else
  assign stall_cnt = '0;
  assign xfer_cnt  = '0;
`endif

endmodule

// File: tb/tb_simd_pipe_stage.sv
// Scoreboard bench for simd_pipe_stage: a queue model of the held entries predicts
// in_ready/out_valid/out_data and the statistics counters every cycle.
module tb_simd_pipe_stage;
  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cnt, xfer_cnt;

  // second instance with 4-bit counters for the saturation check
  logic          s_in_valid = 1'b0;
  logic          s_in_ready;
  logic [DW-1:0] s_in_data = 8'h77;
  logic          s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [3:0]    s_stall, s_xfer;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  simd_pipe_stage #(.DATA_W(DW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt), .xfer_cnt(xfer_cnt)
  );

  simd_pipe_stage #(.DATA_W(DW), .CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
    .out_valid(s_out_valid), .out_ready(1'b0), .out_data(s_out_data),
    .stall_cnt(s_stall), .xfer_cnt(s_xfer)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // model state
  logic [DW-1:0] q[$];
  int  m_stall = 0;
  int  m_xfer  = 0;
  bit  m_acc   = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_stall = 0;
      m_xfer  = 0;
      m_acc   = 0;
    end else begin
      bit dlv, acc;
      dlv = (q.size() > 0) && out_ready;
      acc = in_valid && (q.size() < 2) && !flush;
      if ((q.size() > 0) && !out_ready && m_stall < 65535) m_stall++;
      if (dlv && m_xfer < 65535) m_xfer++;
      if (flush) q.delete();
      else begin
        if (dlv) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
      m_acc = acc;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, q.size() < 2);
      chk("out_valid", out_valid, q.size() > 0);
      if (q.size() > 0) chk("out_data", out_data, q[0]);
`ifdef STAGE_STATS_EN
      chk("stall_cnt", stall_cnt, m_stall);
      chk("xfer_cnt", xfer_cnt, m_xfer);
`else
      chk("stall_cnt_tied", stall_cnt, 0);
      chk("xfer_cnt_tied", xfer_cnt, 0);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [DW-1:0] d);
    int n;
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!m_acc && n < 50);
    if (!m_acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic async_reset_check(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_data"}, out_data, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #2;
    async_reset_check("rst0");
    repeat (5) tick();

    // streaming
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) send(DW'(i));
    repeat (3) tick();
`ifdef STAGE_STATS_EN
    chk("xfer_after_stream", xfer_cnt, 16);
`endif

    // backpressure into the skid entry
    out_ready = 1'b0;
    send(8'h0A);
    send(8'h0B);
    in_valid = 1'b1;
    in_data  = 8'h0C;
    repeat (4) tick();
    chk("full_in_ready", in_ready, 0);
    chk("full_head", out_data, 8'h0A);
    out_ready = 1'b1;
    send(8'h0C);
    repeat (4) tick();

    // flush while FULL with a word offered
    out_ready = 1'b0;
    send(8'h0A);
    send(8'h0B);
    in_valid = 1'b1;
    in_data  = 8'h0C;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (3) tick();

    // flush in BUSY dominates a same-cycle accept
    out_ready = 1'b0;
    send(8'h21);
    in_valid = 1'b1;
    in_data  = 8'h22;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_busy_out_valid", out_valid, 0);
    repeat (2) tick();

    // simultaneous accept and deliver in BUSY
    send(8'h05);
    out_ready = 1'b1;
    send(8'h06);
    chk("simul_main", out_data, 8'h06);
    chk("simul_in_ready", in_ready, 1);
    in_valid = 1'b0;
    repeat (3) tick();

    // reset while holding words
    out_ready = 1'b0;
    send(8'h31);
    send(8'h32);
    async_reset_check("rst_mid");
    repeat (2) tick();

    // saturation on the 4-bit instance
    s_in_valid = 1'b1;
    tick();
    s_in_valid = 1'b0;
    repeat (20) tick();
    chk("sat_out_valid", s_out_valid, 1);
    chk("sat_data", s_out_data, 8'h77);
`ifdef STAGE_STATS_EN
    chk("sat_stall", s_stall, 15);
    repeat (3) tick();
    chk("sat_stall_hold", s_stall, 15);
`else
    chk("sat_stall_tied", s_stall, 0);
`endif
    chk("sat_xfer", s_xfer, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
